video_mode_seq: RTL and testbench



---
 rtl/video_mode_seq.sv | 118 +++++++++++
 tb/tb_video_mode_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_seq.sv
// Frame-synchronous RGB/YPbPr mode sequencer: applies converter enable changes on vsync
// and mutes the output for MUTE_FRAMES frames around each change.
//
// state | meaning
// RUN   | settled, conv_ena matches the request, output unmuted
// PEND  | request differs from conv_ena, waiting for the next frame tick
// MUTE  | new mode applied, counting muted frames before release
module video_mode_seq #(
    parameter int MUTE_FRAMES = 2,
    parameter int TIMEOUT_W   = 22,
    parameter int VS_POL      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ypbpr_req,
    input  logic vs_in,
    output logic conv_ena,
    output logic blank,
    output logic busy
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PEND = 2'd1,
        S_MUTE = 2'd2
    } state_t;

    localparam logic       VS_ACT    = (VS_POL != 0);
    localparam logic [3:0] FCNT_LAST = 4'(MUTE_FRAMES - 1);

    state_t               state, state_nxt;
    logic [3:0]           fcnt, fcnt_nxt;
    logic                 ena_nxt, blank_nxt, busy_nxt;
    logic                 vs_a, vs_d, vs_edge;
    logic [TIMEOUT_W-1:0] wd;
    logic                 wd_full, tick;

    assign vs_a    = vs_in ^ ~VS_ACT;
    assign vs_edge = vs_a & ~vs_d;
    assign wd_full = &wd;
    assign tick    = vs_edge | wd_full;

    // Watchdog restarts on every frame event so a missing vsync still advances the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_d <= 1'b0;
            wd   <= '0;
        end else begin
            vs_d <= vs_a;
            if (tick)
                wd <= '0;
            else
                wd <= wd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_MUTE;
            fcnt     <= 4'd0;
            conv_ena <= 1'b0;
            blank    <= 1'b1;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            conv_ena <= ena_nxt;
            blank    <= blank_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        ena_nxt   = conv_ena;
        blank_nxt = blank;
        case (state)
            S_RUN: begin
                blank_nxt = 1'b0;
                if (ypbpr_req != conv_ena)
                    state_nxt = S_PEND;
            end
            S_PEND: begin
                // A withdrawn request wins over a coincident tick.
                if (ypbpr_req == conv_ena) begin
                    state_nxt = S_RUN;
                    blank_nxt = 1'b0;
                end else if (tick) begin
                    ena_nxt   = ypbpr_req;
                    blank_nxt = 1'b1;
                    fcnt_nxt  = 4'd0;
                    state_nxt = S_MUTE;
                end
            end
            S_MUTE: begin
                if (tick) begin
                    fcnt_nxt = fcnt + 4'd1;
                    if (fcnt == FCNT_LAST) begin
                        if (ypbpr_req == conv_ena) begin
                            blank_nxt = 1'b0;
                            state_nxt = S_RUN;
                        end else begin
                            state_nxt = S_PEND;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_MUTE;
                fcnt_nxt  = 4'd0;
                blank_nxt = 1'b1;
            end
        endcase
        busy_nxt = (state_nxt != S_RUN);
    end

endmodule

// File: tb/tb_video_mode_seq.sv
// Bench for video_mode_seq: directed scenarios plus randomized request/vsync traffic,
// all outputs compared every cycle against a frame-level reference model.
module tb_video_mode_seq;

    localparam int MF        = 2;
    localparam int TW        = 8;
    localparam int VP        = 1;
    localparam int WD_PERIOD = 2 ** TW;

    localparam int P_RUN  = 0;
    localparam int P_WAIT = 1;
    localparam int P_MUTE = 2;

    logic clk       = 1'b0;
    logic reset_n   = 1'b1;
    logic ypbpr_req = 1'b0;
    logic vs_in     = 1'b0;
    logic conv_ena, blank, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    video_mode_seq #(.MUTE_FRAMES(MF), .TIMEOUT_W(TW), .VS_POL(VP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ypbpr_req (ypbpr_req),
        .vs_in     (vs_in),
        .conv_ena  (conv_ena),
        .blank     (blank),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase of the mode change, frames of mute still owed,
    // and cycles elapsed since the last frame event.
    int phase, frames_left, since_tick;
    bit va_prev, m_va, m_tick, m_ena, m_blank;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       = P_MUTE;
            frames_left = MF;
            since_tick  = 0;
            va_prev     = 1'b0;
            m_ena       = 1'b0;
            m_blank     = 1'b1;
        end else begin
            m_va       = (VP != 0) ? vs_in : !vs_in;
            m_tick     = (m_va && !va_prev) || (since_tick == WD_PERIOD - 1);
            va_prev    = m_va;
            since_tick = m_tick ? 0 : since_tick + 1;
            case (phase)
                P_RUN: if (ypbpr_req != m_ena) phase = P_WAIT;
                P_WAIT: begin
                    if (ypbpr_req == m_ena) begin
                        phase   = P_RUN;
                        m_blank = 1'b0;
                    end else if (m_tick) begin
                        m_ena       = ypbpr_req;
                        m_blank     = 1'b1;
                        frames_left = MF;
                        phase       = P_MUTE;
                    end
                end
                default: begin
                    if (m_tick) begin
                        frames_left--;
                        if (frames_left == 0) begin
                            if (ypbpr_req == m_ena) begin
                                m_blank = 1'b0;
                                phase   = P_RUN;
                            end else begin
                                phase = P_WAIT;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_conv_ena", conv_ena, m_ena);
            chk("model_blank", blank, m_blank);
            chk("model_busy", busy, (phase != P_RUN));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic edge_now();
        vs_in = 1'b1;
        step(1);
    endtask

    task automatic finish_pulse();
        step(2);
        vs_in = 1'b0;
        step(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int gap;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_conv_ena", conv_ena, 0);
        chk("rst_blank", blank, 1);
        chk("rst_busy", busy, 1);
        chk_on = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(5);

        // Power-up mute release with RGB requested
        edge_now();
        chk("t1_e1_blank", blank, 1);
        finish_pulse();
        edge_now();
        chk("t1_e2_blank", blank, 0);
        chk("t1_e2_busy", busy, 0);
        finish_pulse();
        edge_now();
        chk("t1_e3_conv_ena", conv_ena, 0);
        finish_pulse();

        // RGB -> YPbPr with the vsync 100 cycles later
        ypbpr_req = 1'b1;
        step(1);
        chk("t2_busy", busy, 1);
        chk("t2_ena_hold", conv_ena, 0);
        step(98);
        edge_now();
        chk("t2_apply_ena", conv_ena, 1);
        chk("t2_apply_blank", blank, 1);
        finish_pulse();
        edge_now();
        chk("t2_mute1_blank", blank, 1);
        finish_pulse();
        edge_now();
        chk("t2_release_blank", blank, 0);
        chk("t2_release_busy", busy, 0);
        finish_pulse();

        // Request withdrawn before any vsync
        ypbpr_req = 1'b0;
        step(1);
        chk("t3_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            step(1);
            chk("t3_blank", blank, 0);
        end
        ypbpr_req = 1'b1;
        step(1);
        chk("t3_busy_clear", busy, 0);
        chk("t3_ena_kept", conv_ena, 1);
        chk("t3_blank_end", blank, 0);

        // No video: the watchdog drives the change
        ypbpr_req = 1'b0;
        lat = 0;
        while (conv_ena !== 1'b0 && lat < 3 * WD_PERIOD) begin
            step(1);
            lat++;
        end
        chk("t4_apply_in_time", (lat <= WD_PERIOD) ? 1 : 0, 1);
        chk("t4_blank_on", blank, 1);
        n = 0;
        while (blank !== 1'b0 && n < 4 * WD_PERIOD) begin
            step(1);
            n++;
        end
        chk("t4_mute_len", n, 2 * WD_PERIOD);
        chk("t4_busy_clear", busy, 0);

        // Request reversed while muting
        ypbpr_req = 1'b1;
        step(3);
        edge_now();
        chk("t5_apply_ena", conv_ena, 1);
        finish_pulse();
        ypbpr_req = 1'b0;
        edge_now();
        chk("t5_mute_ena", conv_ena, 1);
        finish_pulse();
        edge_now();
        chk("t5_mute_done_ena", conv_ena, 1);
        chk("t5_mute_done_blank", blank, 1);
        chk("t5_mute_done_busy", busy, 1);
        finish_pulse();
        edge_now();
        chk("t5_reapply_ena", conv_ena, 0);
        chk("t5_reapply_blank", blank, 1);
        finish_pulse();
        edge_now();
        chk("t5_remute_blank", blank, 1);
        finish_pulse();
        edge_now();
        chk("t5_release_blank", blank, 0);
        chk("t5_release_ena", conv_ena, 0);
        finish_pulse();

        // Asynchronous reset in the middle of a mute
        ypbpr_req = 1'b1;
        step(2);
        edge_now();
        chk("t6_pre_ena", conv_ena, 1);
        step(4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_ena", conv_ena, 0);
        chk("t6_rst_blank", blank, 1);
        chk("t6_rst_busy", busy, 1);
        step(2);
        vs_in = 1'b0;
        reset_n = 1'b1;
        step(5);

        // Randomized traffic, occasional lost video and resets
        repeat (60) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(260, 700) : $urandom_range(2, 200);
            for (int i = 0; i < gap; i++) begin
                if ($urandom_range(0, 39) == 0) ypbpr_req = ~ypbpr_req;
                step(1);
            end
            vs_in = 1'b1;
            step($urandom_range(1, 4));
            vs_in = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                #2 reset_n = 1'b0;
                step(2);
                reset_n = 1'b1;
            end
            step(1);
        end

        step(2);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
